sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 175 +++++++++++++++++
 tb/tb_sram_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
//
// Purpose
//   Bridges the 32-bit MEM stage of the CPU pipeline to a 16-bit asynchronous
//   SRAM. Each load or store is split into two halfword accesses. The low
//   halfword comes first and the high halfword second. Each access is held for
//   two clock cycles so that the SRAM has settled before data is sampled.
//   The pipeline is frozen (ready low) until the access completes.
//
//   Sequence of one operation:
//     IDLE (request seen) -> LOW_A -> LOW_B -> HIGH_A -> HIGH_B -> DONE -> IDLE
//   ready is high only in IDLE without a request and in DONE. An operation
//   therefore costs six cycles, with the pipeline held for five of them.
//
//   Byte addresses start at 1024 in the CPU map. The SRAM word index is
//   w = (address - 1024) >> 2, kept to 17 bits. It wraps silently, including
//   for addresses below 1024. Halfword h of word w is at SRAM address {w, h}.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous reset, active high
//   wr_en        in   1   store request from the MEM stage
//   rd_en        in   1   load request from the MEM stage (store wins if both)
//   address      in   32  byte address (ALU result)
//   write_data   in   32  store data
//   read_data    out  32  load result, registered, held until the next load
//   ready        out  1   MEM stage may advance (combinational)
//   sram_addr    out  18  SRAM halfword address
//   sram_we_n    out  1   SRAM write enable, active low
//   sram_dq_out  out  16  data for the SRAM bus during stores
//   sram_dq_oe   out  1   bus drive enable; the top level tristates when low
//   sram_dq_in   in   16  data sampled from the SRAM bus
// ----------------------------------------------------------------------------
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOW_A  = 3'd1,
        LOW_B  = 3'd2,
        HIGH_A = 3'd3,
        HIGH_B = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] SRAM_BASE = 32'd1024;

    // ------------------------------------------------------------------
    // State and latched operation
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        is_wr_q;       // operation type captured at start
    logic [16:0] word_q;        // word index captured at start
    logic [15:0] wdata_hi_q;    // upper store halfword, driven in the HIGH states

    // Registered outputs
    logic [31:0] read_data_q;
    logic [17:0] sram_addr_q;
    logic        sram_we_n_q;
    logic [15:0] sram_dq_out_q;
    logic        sram_dq_oe_q;

    // Combinational helpers
    logic        req_d;
    logic [16:0] word_d;

    assign req_d  = wr_en | rd_en;

    // Subtraction and truncation together give the modulo-2^17 wrap.
    // No range check is made, so an address below the base simply wraps.
    assign word_d = 17'((address - SRAM_BASE) >> 2);

    // ready must drop in the same cycle that a request arrives, so it is
    // decoded from the current state and the live request. It cannot be
    // registered.
    assign ready = ((state_q == IDLE) && !req_d) || (state_q == DONE);

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;

    // ------------------------------------------------------------------
    // Controller FSM. The SRAM-side outputs are registered. Each one is
    // loaded on the edge that enters the state where it must appear, so
    // the SRAM pins never glitch during an access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            is_wr_q       <= 1'b0;
            word_q        <= '0;
            wdata_hi_q    <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_we_n_q   <= 1'b1;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        // wr_en takes priority when both requests are present.
                        state_q       <= LOW_A;
                        is_wr_q       <= wr_en;
                        word_q        <= word_d;
                        wdata_hi_q    <= write_data[31:16];
                        sram_addr_q   <= {word_d, 1'b0};
                        sram_we_n_q   <= ~wr_en;
                        sram_dq_oe_q  <= wr_en;
                        sram_dq_out_q <= wr_en ? write_data[15:0] : 16'h0000;
                    end
                end

                LOW_A: begin
                    state_q <= LOW_B;
                end

                LOW_B: begin
                    // The low halfword has been addressed for two cycles.
                    // A load samples it here. A store switches to the high half.
                    state_q     <= HIGH_A;
                    sram_addr_q <= {word_q, 1'b1};
                    if (is_wr_q) begin
                        sram_dq_out_q <= wdata_hi_q;
                    end else begin
                        read_data_q[15:0] <= sram_dq_in;
                    end
                end

                HIGH_A: begin
                    state_q <= HIGH_B;
                end

                HIGH_B: begin
                    // Release the bus and the write strobe as the access finishes.
                    state_q       <= DONE;
                    sram_addr_q   <= '0;
                    sram_we_n_q   <= 1'b1;
                    sram_dq_oe_q  <= 1'b0;
                    sram_dq_out_q <= '0;
                    if (!is_wr_q) begin
                        read_data_q[31:16] <= sram_dq_in;
                    end
                end

                DONE: begin
                    // A request seen here is not accepted yet.
                    // It is picked up from IDLE in the next cycle.
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in)
    );

    // Read-only SRAM contents: fixed words at 4/5, a scrambled pattern elsewhere.
    function automatic logic [15:0] sram_val(input logic [17:0] a);
        logic [15:0] t;
        if (a == 18'd4) return 16'hBEEF;
        if (a == 18'd5) return 16'hDEAD;
        t = a[15:0] ^ {14'd0, a[17:16]};
        return (t * 16'h1357) ^ 16'h2468;
    endfunction

    assign sram_dq_in = sram_val(sram_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_k counts cycles into an accepted operation: 0 idle, 1..4 the two
    // halfword accesses (2 cycles each), 5 completion cycle.
    int          m_k = 0;
    logic        m_wr = 1'b0;
    logic [16:0] m_w = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rd = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_k  = 0;
            m_rd = '0;
        end else if (m_k == 0) begin
            if (wr_en || rd_en) begin
                m_k    = 1;
                m_wr   = wr_en;
                m_w    = 17'((address - 32'd1024) >> 2);
                m_data = write_data;
            end
        end else if (m_k == 5) begin
            m_k = 0;
        end else begin
            if (!m_wr && m_k == 2) m_rd[15:0]  = sram_val({m_w, 1'b0});
            if (!m_wr && m_k == 4) m_rd[31:16] = sram_val({m_w, 1'b1});
            m_k = m_k + 1;
        end
    end

    always @(negedge clk) begin
        logic        busy, hi;
        logic [17:0] e_addr;
        logic        e_ready;
        if (!rst) begin
            busy    = (m_k >= 1) && (m_k <= 4);
            hi      = (m_k >= 3);
            e_addr  = busy ? {m_w, hi} : 18'd0;
            e_ready = ((m_k == 0) && !(wr_en || rd_en)) || (m_k == 5);
            chk("model_ready", {31'd0, ready}, {31'd0, e_ready});
            chk("model_addr", {14'd0, sram_addr}, {14'd0, e_addr});
            chk("model_we_n", {31'd0, sram_we_n}, {31'd0, !(busy && m_wr)});
            chk("model_oe", {31'd0, sram_dq_oe}, {31'd0, busy && m_wr});
            chk("model_rdata", read_data, m_rd);
            if (busy && m_wr)
                chk("model_dq_out", {16'd0, sram_dq_out},
                    {16'd0, hi ? m_data[31:16] : m_data[15:0]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed vectors ----------------
    initial begin
        logic [17:0] exp_a [0:4];
        logic [15:0] exp_d [0:4];
        int rlow;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);

        // Store 0xDEADBEEF at 1024+8 -> halfwords 4 (0xBEEF) and 5 (0xDEAD)
        exp_a[1] = 18'd4; exp_a[2] = 18'd4; exp_a[3] = 18'd5; exp_a[4] = 18'd5;
        exp_d[1] = 16'hBEEF; exp_d[2] = 16'hBEEF; exp_d[3] = 16'hDEAD; exp_d[4] = 16'hDEAD;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
        rlow = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!ready) rlow++;
            if (c == 0) chk("wr_req_ready", {31'd0, ready}, 32'd0);
            if (c >= 1 && c <= 4) begin
                chk("wr_addr", {14'd0, sram_addr}, {14'd0, exp_a[c]});
                chk("wr_dq", {16'd0, sram_dq_out}, {16'd0, exp_d[c]});
                chk("wr_we_n", {31'd0, sram_we_n}, 32'd0);
            end
            if (c == 5) begin
                chk("wr_done_ready", {31'd0, ready}, 32'd1);
                chk("wr_done_we_n", {31'd0, sram_we_n}, 32'd1);
            end
        end
        chk("wr_ready_low_cycles", rlow, 32'd5);
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (2) @(posedge clk);

        // Load from 1024+8 -> 0xDEADBEEF
        #1;
        rd_en = 1'b1; address = 32'd1032;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                chk("rd_addr", {14'd0, sram_addr}, {14'd0, exp_a[c]});
                chk("rd_we_n", {31'd0, sram_we_n}, 32'd1);
                chk("rd_oe", {31'd0, sram_dq_oe}, 32'd0);
            end
            if (c == 5) chk("rd_done_data", read_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);

        // Both requests high: store executes, read_data untouched
        #1;
        wr_en = 1'b1; rd_en = 1'b1; address = 32'd1040; write_data = 32'h12345678;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("both_we_n", {31'd0, sram_we_n}, 32'd0);
                chk("both_addr", {14'd0, sram_addr}, 32'd8);
                chk("both_dq", {16'd0, sram_dq_out}, 32'h5678);
            end
            if (c == 5) chk("both_rdata_kept", read_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);

        // Request dropped after one cycle still completes
        #1;
        rd_en = 1'b1; address = 32'd1064;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                @(posedge clk); #1;
                rd_en = 1'b0;
            end
            if (c >= 1 && c <= 4) chk("drop_busy_ready", {31'd0, ready}, 32'd0);
            if (c == 5) begin
                chk("drop_done_ready", {31'd0, ready}, 32'd1);
                chk("drop_rdata", read_data, {sram_val(18'd21), sram_val(18'd20)});
            end
            if (c == 6) chk("drop_idle_ready", {31'd0, ready}, 32'd1);
        end
        repeat (2) @(posedge clk);

        // Back-to-back: request held through DONE restarts 2 cycles later
        #1;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hA5A55A5A;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 5) chk("b2b_done_ready", {31'd0, ready}, 32'd1);
            if (c == 6) begin
                chk("b2b_idle_ready", {31'd0, ready}, 32'd0);
                chk("b2b_idle_we_n", {31'd0, sram_we_n}, 32'd1);
            end
            if (c == 7) begin
                chk("b2b_second_we_n", {31'd0, sram_we_n}, 32'd0);
                chk("b2b_second_addr", {14'd0, sram_addr}, 32'd4);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (8) @(posedge clk);

        // Address wrap below the base: w = 0x1FF00
        #1;
        rd_en = 1'b1; address = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("wrap_lo_addr", {14'd0, sram_addr}, 32'h3FE00);
            if (c == 3) chk("wrap_hi_addr", {14'd0, sram_addr}, 32'h3FE01);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);

        // Address wrap above: 1024 + 4*2^17 maps to word 0
        #1;
        wr_en = 1'b1; address = 32'h0008_0400; write_data = 32'h0BADF00D;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("wrap2_lo_addr", {14'd0, sram_addr}, 32'd0);
                chk("wrap2_we_n", {31'd0, sram_we_n}, 32'd0);
            end
            if (c == 3) chk("wrap2_hi_addr", {14'd0, sram_addr}, 32'd1);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset during HIGH_A of a store
        #1;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) @(negedge clk);
        chk("pre_rst_addr", {14'd0, sram_addr}, 32'd5);
        #1;
        rst = 1'b1; wr_en = 1'b0;
        #1;
        chk("arst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("arst_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("arst_addr", {14'd0, sram_addr}, 32'd0);
        chk("arst_dq", {16'd0, sram_dq_out}, 32'd0);
        chk("arst_rdata", read_data, 32'd0);
        chk("arst_ready_idle", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
